// File: rtl/risc_pkg.sv
// Shared defaults and FSM encoding for the program loader.
// No ports: imported by prog_loader.
package risc_pkg;

  localparam int RISC_ADDR_W = 5;
  localparam int RISC_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } ld_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Program byte stream bundle (valid/ready/data/last).
// master drives valid/data/last, slave drives ready.
interface prog_loader_if #(
  parameter int DATA_W = 8
) (
  input logic clk
);

  logic              valid;
  logic              ready;
  logic              last;
  logic [DATA_W-1:0] data;

  modport master (
    input  clk, ready,
    output valid, data, last
  );

  modport slave (
    input  clk, valid, data, last,
    output ready
  );

endinterface

// File: rtl/prog_loader.sv
// Streams a program into CPU memory, releases the CPU, and
// watches it until halt or a cycle-limit timeout.
// Ports: clk, rst (sync, active-low); s_valid/s_data/s_last/
// s_ready byte stream; mem_we/mem_addr/mem_wdata CPU memory
// write; cpu_rst/cpu_halt/cpu_pc CPU control; done/halt_pc/
// cycles/timeout run result.
module prog_loader
  import risc_pkg::*;
#(
  parameter int ADDR_W     = RISC_ADDR_W,
  parameter int DATA_W     = RISC_DATA_W,
  parameter int MAX_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  input  logic              cpu_halt,
  input  logic [ADDR_W-1:0] cpu_pc,
  output logic              done,
  output logic [ADDR_W-1:0] halt_pc,
  output logic [15:0]       cycles,
  output logic              timeout
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [15:0] CYC_LAST = 16'(MAX_CYCLES - 1);

  ld_state_t         state_q, state_d;
  logic              s_ready_q, s_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] halt_pc_q, halt_pc_d;
  logic [15:0]       cycles_q, cycles_d;
  logic              timeout_q, timeout_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic              accept;

  // s_ready_q is only ever high in LOAD, so this also
  // gates out any stream activity in the other states.
  assign accept = s_valid && s_ready_q;

  always_comb begin
    state_d     = state_q;
    s_ready_d   = s_ready_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rst_d   = cpu_rst_q;
    done_d      = done_q;
    halt_pc_d   = halt_pc_q;
    cycles_d    = cycles_q;
    timeout_d   = timeout_q;
    wr_cnt_d    = wr_cnt_q;
    unique case (state_q)
      ST_LOAD: begin
        s_ready_d = 1'b1;
        cpu_rst_d = 1'b1;
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_cnt_q;
          mem_wdata_d = s_data;
          // saturate rather than wrap at the top address
          if (wr_cnt_q != ADDR_MAX)
            wr_cnt_d = wr_cnt_q + 1'b1;
          if (s_last || wr_cnt_q == ADDR_MAX) begin
            state_d   = ST_DRAIN;
            s_ready_d = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        state_d   = ST_RUN;
        cpu_rst_d = 1'b0;
        cycles_d  = '0;
      end
      ST_RUN: begin
        if (cpu_halt) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          halt_pc_d = cpu_pc;
          timeout_d = 1'b0;
        end else if (cycles_q == CYC_LAST) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          halt_pc_d = cpu_pc;
          timeout_d = 1'b1;
          cpu_rst_d = 1'b1;
        end else begin
          cycles_d = cycles_q + 16'd1;
        end
      end
      ST_DONE: begin
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_LOAD;
      s_ready_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
      halt_pc_q   <= '0;
      cycles_q    <= '0;
      timeout_q   <= 1'b0;
      wr_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      s_ready_q   <= s_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_q   <= cpu_rst_d;
      done_q      <= done_d;
      halt_pc_q   <= halt_pc_d;
      cycles_q    <= cycles_d;
      timeout_q   <= timeout_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst   = cpu_rst_q;
  assign done      = done_q;
  assign halt_pc   = halt_pc_q;
  assign cycles    = cycles_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (MAX_CYCLES=100) with a
// tiny CPU model whose pc counts up while out of reset.
module tb_prog_loader;

  localparam int AW = 5;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  prog_loader_if #(.DATA_W(DW)) sif (.clk(clk));

  logic          mem_we, cpu_rst, cpu_halt, done, timeout;
  logic [AW-1:0] mem_addr, cpu_pc, halt_pc;
  logic [DW-1:0] mem_wdata;
  logic [15:0]   cycles;

  int n_chk = 0;
  int n_fail = 0;

  // 1: halt at pc 0x17, 2: never halt, 3: halt at cycles 99
  int mode = 0;
  logic [4:0] pc = '0;

  logic [AW-1:0] wr_a [64];
  logic [DW-1:0] wr_d [64];
  int wcnt = 0;

  prog_loader #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(sif.valid), .s_data(sif.data),
    .s_last(sif.last), .s_ready(sif.ready),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_rst(cpu_rst),
    .cpu_halt(cpu_halt), .cpu_pc(cpu_pc),
    .done(done), .halt_pc(halt_pc),
    .cycles(cycles), .timeout(timeout)
  );

  always @(posedge clk)
    if (cpu_rst) pc <= '0;
    else pc <= pc + 5'd1;

  assign cpu_pc = pc;
  assign cpu_halt = (mode == 1 && pc == 5'h17) ||
                    (mode == 3 && cycles == 16'd99);

  always @(negedge clk)
    if (mem_we === 1'b1 && wcnt < 64) begin
      wr_a[wcnt] = mem_addr;
      wr_d[wcnt] = mem_wdata;
      wcnt++;
    end

  function automatic logic [7:0] prog_byte(int i);
    return 8'((i * 7 + 49) & 255);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    sif.valid = 1'b0;
    sif.last = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wcnt = 0;
  endtask

  task automatic send(int n, bit use_last, bit gap);
    int i = 0;
    int cyc = 0;
    bit acc;
    while (i < n && cyc < 400) begin
      @(negedge clk);
      sif.valid = gap ? cyc[0] : 1'b1;
      sif.data = prog_byte(i);
      sif.last = use_last && (i == n - 1);
      acc = sif.valid && sif.ready;
      @(posedge clk);
      if (acc) i++;
      cyc++;
    end
    n_chk++;
    if (i != n) begin
      n_fail++;
      $display("FAIL send_accept: got %0d bytes exp %0d", i, n);
    end
  endtask

  task automatic wait_done();
    int k = 0;
    @(negedge clk);
    while (done !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_timeout: done=%b exp 1", done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    sif.valid = 1'b0;
    sif.last = 1'b0;
    sif.data = '0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({sif.ready, mem_we, mem_addr, mem_wdata}
        !== {1'b0, 1'b0, 5'h0, 8'h0}) begin
      n_fail++;
      $display("FAIL rst_bus: got %b%b %h %h exp 00 0 0",
               sif.ready, mem_we, mem_addr, mem_wdata);
    end
    n_chk++;
    if ({cpu_rst, done, timeout, halt_pc, cycles}
        !== {1'b1, 1'b0, 1'b0, 5'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL rst_ctl: got %b%b%b %h %h exp 100 0 0",
               cpu_rst, done, timeout, halt_pc, cycles);
    end
    rst = 1'b1;
    wcnt = 0;
    @(negedge clk);
    n_chk++;
    if (sif.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready: got %b exp 1", sif.ready);
    end
  endtask

  task automatic test_halt(bit gap);
    int bad = 0;
    do_reset();
    mode = 1;
    send(24, 1'b1, gap);
    @(negedge clk);
    sif.valid = 1'b0;
    wait_done();
    n_chk++;
    if (wcnt != 24) begin
      n_fail++;
      $display("FAIL halt_wcnt g%0d: got %0d exp 24", gap, wcnt);
    end
    for (int i = 0; i < 24 && i < wcnt; i++) begin
      n_chk++;
      if (wr_a[i] !== AW'(i) || wr_d[i] !== prog_byte(i)) begin
        n_fail++;
        bad++;
        if (bad < 4)
          $display("FAIL halt_wr g%0d #%0d: got %h/%h exp %h/%h",
                   gap, i, wr_a[i], wr_d[i], i, prog_byte(i));
      end
    end
    n_chk++;
    if ({timeout, halt_pc, cycles, cpu_rst}
        !== {1'b0, 5'h17, 16'd23, 1'b0}) begin
      n_fail++;
      $display("FAIL halt_res g%0d: got %b %h %0d %b exp 0 17 23 0",
               gap, timeout, halt_pc, cycles, cpu_rst);
    end
    repeat (5) @(negedge clk);
    n_chk++;
    if ({done, halt_pc, cycles} !== {1'b1, 5'h17, 16'd23}) begin
      n_fail++;
      $display("FAIL halt_frozen g%0d: got %b %h %0d exp 1 17 23",
               gap, done, halt_pc, cycles);
    end
  endtask

  task automatic test_full_mem();
    do_reset();
    mode = 2;
    send(32, 1'b0, 1'b0);
    @(negedge clk);
    n_chk++;
    if ({mem_we, mem_addr, mem_wdata, sif.ready, cpu_rst}
        !== {1'b1, 5'h1f, prog_byte(31), 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL drain: got %b %h %h %b %b exp 1 1f %h 0 1",
               mem_we, mem_addr, mem_wdata, sif.ready, cpu_rst,
               prog_byte(31));
    end
    sif.data = 8'hEE;
    @(negedge clk);
    n_chk++;
    if ({mem_we, sif.ready, cpu_rst, cycles}
        !== {1'b0, 1'b0, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL run_entry: got %b %b %b %0d exp 0 0 0 0",
               mem_we, sif.ready, cpu_rst, cycles);
    end
    repeat (4) @(negedge clk);
    n_chk++;
    if (wcnt != 32 || sif.ready !== 1'b0 || cycles !== 16'd4) begin
      n_fail++;
      $display("FAIL ignore_valid: got %0d %b %0d exp 32 0 4",
               wcnt, sif.ready, cycles);
    end
    sif.valid = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    mode = 2;
    send(4, 1'b1, 1'b0);
    @(negedge clk);
    sif.valid = 1'b0;
    wait_done();
    n_chk++;
    if ({timeout, cycles, cpu_rst, halt_pc}
        !== {1'b1, 16'd99, 1'b1, 5'h03}) begin
      n_fail++;
      $display("FAIL timeout: got %b %0d %b %h exp 1 99 1 03",
               timeout, cycles, cpu_rst, halt_pc);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if ({done, timeout, cycles} !== {1'b1, 1'b1, 16'd99}) begin
      n_fail++;
      $display("FAIL timeout_frozen: got %b %b %0d exp 1 1 99",
               done, timeout, cycles);
    end
  endtask

  task automatic test_halt_at_limit();
    do_reset();
    mode = 3;
    send(4, 1'b1, 1'b0);
    @(negedge clk);
    sif.valid = 1'b0;
    wait_done();
    n_chk++;
    if ({timeout, cycles, cpu_rst, halt_pc}
        !== {1'b0, 16'd99, 1'b0, 5'h03}) begin
      n_fail++;
      $display("FAIL halt_limit: got %b %0d %b %h exp 0 99 0 03",
               timeout, cycles, cpu_rst, halt_pc);
    end
  endtask

  task automatic test_reset_in_run();
    do_reset();
    mode = 2;
    send(4, 1'b1, 1'b0);
    @(negedge clk);
    sif.valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({cpu_rst, cycles, sif.ready, done, mem_addr}
        !== {1'b1, 16'd0, 1'b0, 1'b0, 5'h0}) begin
      n_fail++;
      $display("FAIL run_rst: got %b %0d %b %b %h exp 1 0 0 0 0",
               cpu_rst, cycles, sif.ready, done, mem_addr);
    end
    rst = 1'b1;
    wcnt = 0;
    @(negedge clk);
    n_chk++;
    if ({sif.ready, cpu_rst} !== 2'b11) begin
      n_fail++;
      $display("FAIL run_rst_ready: got %b%b exp 11",
               sif.ready, cpu_rst);
    end
    send(1, 1'b1, 1'b0);
    @(negedge clk);
    sif.valid = 1'b0;
    n_chk++;
    if ({mem_we, mem_addr, mem_wdata}
        !== {1'b1, 5'h0, prog_byte(0)}) begin
      n_fail++;
      $display("FAIL reload_addr: got %b %h %h exp 1 00 %h",
               mem_we, mem_addr, mem_wdata, prog_byte(0));
    end
  endtask

  initial begin
    sif.valid = 1'b0;
    sif.last = 1'b0;
    sif.data = '0;
    test_reset();
    test_halt(1'b0);
    test_halt(1'b1);
    test_full_mem();
    test_timeout();
    test_halt_at_limit();
    test_reset_in_run();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 5: CPU memory address width.
REQ-002 SHALL have parameter DATA_W, default 8: CPU memory data width.
REQ-003 SHALL have parameter MAX_CYCLES, default 1000: run-cycle limit before timeout, range 1..65535.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port s_valid  input  1  program byte valid.
REQ-007 SHALL have port s_data  input  DATA_W  program byte.
REQ-008 SHALL have port s_last  input  1  marks the final program byte.
REQ-009 SHALL have port s_ready  output  1  loader accepts a byte.
REQ-010 SHALL have port mem_we  output  1  CPU memory write strobe.
REQ-011 SHALL have port mem_addr  output  ADDR_W  CPU memory write address.
REQ-012 SHALL have port mem_wdata  output  DATA_W  CPU memory write data.
REQ-013 SHALL have port cpu_rst  output  1  active-high reset to the CPU.
REQ-014 SHALL have port cpu_halt  input  1  CPU halt flag.
REQ-015 SHALL have port cpu_pc  input  ADDR_W  CPU program counter.
REQ-016 SHALL have port done  output  1  run finished (halt or timeout).
REQ-017 SHALL have port halt_pc  output  ADDR_W  cpu_pc captured at finish.
REQ-018 SHALL have port cycles  output  16  CPU cycles elapsed in RUN.
REQ-019 SHALL have port timeout  output  1  run ended by MAX_CYCLES, not halt.

Function
REQ-020 SHALL implement states LOAD, DRAIN, RUN, DONE; reset state LOAD.
REQ-021 In LOAD: s_ready=1 and cpu_rst=1; a byte is accepted when s_valid && s_ready.
REQ-022 Accepted byte in cycle N SHALL appear as mem_we=1, mem_addr=write counter, mem_wdata=s_data in cycle N+1 (registered, one-cycle latency); mem_we=0 otherwise.
REQ-023 Write counter SHALL start at 0 and increment per accepted byte; it never wraps.
REQ-024 Acceptance with s_last=1, or of the byte at address 2^ADDR_W-1, SHALL move LOAD->DRAIN; s_data bytes after that are not accepted.
REQ-025 DRAIN SHALL last exactly one cycle (final write cycle) with s_ready=0, cpu_rst=1, then move to RUN.
REQ-026 In RUN: cpu_rst=0, s_ready=0, cycles increments by 1 every cycle starting from 0 on RUN entry.
REQ-027 In RUN, cpu_halt=1 SHALL move to DONE, capture halt_pc=cpu_pc, timeout=0.
REQ-028 In RUN, cycles==MAX_CYCLES-1 with cpu_halt=0 SHALL move to DONE with timeout=1, halt_pc=cpu_pc.
REQ-029 Simultaneous halt and limit SHALL resolve as halt (timeout=0).
REQ-030 DONE SHALL hold done=1, halt_pc, timeout, cycles frozen; cpu_rst=0 after halt, cpu_rst=1 after timeout; exit only by reset.
REQ-031 s_valid outside LOAD SHALL be ignored with no side effects.
REQ-032 Gaps in s_valid during LOAD SHALL stall without writes; no byte lost or duplicated.

Reset
REQ-033 On rst=0 at a clock edge: state=LOAD, s_ready=0 during reset then 1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, done=0, halt_pc=0, cycles=0, timeout=0, write counter=0.
REQ-034 Reset mid-LOAD, DRAIN, RUN or DONE SHALL abort immediately; CPU memory contents are not cleared.

Structure
REQ-035 ADDR_W/DATA_W defaults and the state encoding SHALL live in shared package risc_pkg.
REQ-036 No sub-module; single module with one FSM, write counter, cycle counter.

Verification
REQ-037 24-byte program with s_last on byte 24, halting at 0x17 -> 24 writes addr 0x00..0x17, done=1, halt_pc=0x17, timeout=0.
REQ-038 Same program with s_valid toggled every other cycle -> identical memory writes and result.
REQ-039 32 bytes without s_last -> 32nd write at 0x1F, DRAIN then RUN, s_ready=0 afterwards.
REQ-040 MAX_CYCLES=100, looping program -> done=1, timeout=1, cycles=99, cpu_rst=1.
REQ-041 MAX_CYCLES=100, cpu_halt forced at cycles=99 -> timeout=0, halt_pc=cpu_pc.
REQ-042 rst=0 for one cycle during RUN -> cpu_rst=1, state LOAD, counters 0, s_ready=1 next cycle.
